// File: rtl/sram_io_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_io_if
// Purpose : Control and address pins of the sram_io bus. The responder also
//           reports here when it is driving the data bus.
// Revision: 1.0 - initial release
// ============================================================================
interface sram_io_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] sram_io_addr;
  logic                  sram_io_we_n;
  logic                  sram_io_oe_n;
  logic                  sram_io_ce_n;
  logic                  sram_io_drive;

  modport master (
    output sram_io_addr, sram_io_we_n, sram_io_oe_n, sram_io_ce_n,
    input  sram_io_drive
  );

  modport slave (
    input  sram_io_addr, sram_io_we_n, sram_io_oe_n, sram_io_ce_n,
    output sram_io_drive
  );
endinterface
`default_nettype wire

// File: rtl/sram_io_responder.sv
`default_nettype none
// ============================================================================
// Module  : sram_io_responder
// Purpose : Clocked SRAM model for the sram_io bus: synchronous writes, reads
//           after READ_LATENCY cycles, sticky protocol-violation flag.
//           Optional macro SRAM_IO_RESPONDER_INIT_EN enables the clear sweep.
// Revision: 1.0 - initial release
// ============================================================================
module sram_io_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  sram_io_if.slave                   bus,
  inout  wire logic [DATA_WIDTH-1:0] sram_io_data,
  output logic                       ready,
  output logic [15:0]                wr_cnt,
  output logic [15:0]                rd_cnt,
  output logic                       proto_err,
  output logic [ADDR_WIDTH-1:0]      err_addr
);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_write    = 2'd1;
  localparam logic [1:0] c_st_rd_wait  = 2'd2;
  localparam logic [1:0] c_st_rd_drive = 2'd3;
  localparam int         c_depth       = 2 ** ADDR_WIDTH;
  localparam logic [1:0] c_lat_load    = 2'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [1:0]            r_state;
  logic [1:0]            r_lat;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [15:0]           r_wr_cnt;
  logic [15:0]           r_rd_cnt;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_ready;

  logic w_wr_cond;
  logic w_rd_cond;
  logic w_access;
  logic w_contention;
  logic w_violation;
  logic w_commit;
  logic w_same_read;
  logic w_drive;

  assign w_wr_cond    = !bus.sram_io_ce_n && !bus.sram_io_we_n;
  assign w_rd_cond    = !bus.sram_io_ce_n && !bus.sram_io_oe_n && bus.sram_io_we_n;
  assign w_access     = !bus.sram_io_ce_n && (!bus.sram_io_we_n || !bus.sram_io_oe_n);
  assign w_contention = w_wr_cond && !bus.sram_io_oe_n;
  assign w_violation  = w_access && (!r_ready || w_contention);
  assign w_commit     = r_ready && w_wr_cond;
  assign w_same_read  = ((r_state == c_st_rd_wait) || (r_state == c_st_rd_drive)) &&
                        (bus.sram_io_addr == r_addr_q);

  // Release is purely combinational on the pins so the bus frees the same cycle.
  assign w_drive           = r_ready && (r_state == c_st_rd_drive) && w_rd_cond;
  assign bus.sram_io_drive = w_drive;
  assign sram_io_data      = w_drive ? r_mem[r_addr_q] : 'z;

  assign ready     = r_ready;
  assign wr_cnt    = r_wr_cnt;
  assign rd_cnt    = r_rd_cnt;
  assign proto_err = r_err;
  assign err_addr  = r_err_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_lat      <= 2'd0;
      r_addr_q   <= '0;
      r_wr_cnt   <= 16'd0;
      r_rd_cnt   <= 16'd0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (w_violation && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= bus.sram_io_addr;
      end
      if (w_commit && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end

      if (!r_ready) begin
        r_state <= c_st_idle;
      end else if (w_wr_cond) begin
        r_state <= c_st_write;
      end else if (w_rd_cond) begin
        if (!w_same_read) begin
          // New read or address moved: restart the latency from scratch.
          r_state  <= c_st_rd_wait;
          r_lat    <= c_lat_load;
          r_addr_q <= bus.sram_io_addr;
        end else if (r_state == c_st_rd_wait) begin
          if (r_lat == 2'd0) begin
            r_state <= c_st_rd_drive;
            if (r_rd_cnt != 16'hFFFF) begin
              r_rd_cnt <= r_rd_cnt + 16'd1;
            end
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
      end else begin
        r_state <= c_st_idle;
      end
    end
  end

`ifdef SRAM_IO_RESPONDER_INIT_EN
  logic                  r_init_busy;
  logic [ADDR_WIDTH-1:0] r_init_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_busy <= 1'b1;
      r_init_addr <= '0;
      r_ready     <= 1'b0;
    end else if (r_init_busy) begin
      r_init_addr <= r_init_addr + 1'b1;
      if (r_init_addr == {ADDR_WIDTH{1'b1}}) begin
        r_init_busy <= 1'b0;
        r_ready     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_init_busy) begin
      r_mem[r_init_addr] <= '0;
    end else if (rst_n && w_commit) begin
      r_mem[bus.sram_io_addr] <= sram_io_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_commit) begin
      r_mem[bus.sram_io_addr] <= sram_io_data;
    end
  end
`endif

endmodule
`default_nettype wire
